// File: rtl/shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_exec_stage
// Function : MIPS execute-stage shift unit. Decodes R-type shift functs,
//            computes the 32-bit shift result in a two-register pipeline
//            (S1 operand capture, S2 result) with valid/ready handshakes on
//            both sides and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module shift_exec_stage #(
   parameter int SHIFT_BITS = 5,
   parameter int DATA_WIDTH = 2 ** SHIFT_BITS,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [5:0]            in_funct,
   input  logic [SHIFT_BITS-1:0] in_shamt,
   input  logic [DATA_WIDTH-1:0] in_rs,
   input  logic [DATA_WIDTH-1:0] in_rt,
   input  logic [REG_ADDR_W-1:0] in_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_illegal,
   output logic                  busy
);

   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;
   localparam logic [5:0] FUNCT_SRLV = 6'b000110;
   localparam logic [5:0] FUNCT_SRAV = 6'b000111;

   // Decoded fields of the incoming op
   logic                  dec_left;
   logic                  dec_arith;
   logic                  dec_var;
   logic                  dec_illegal;
   logic [SHIFT_BITS-1:0] dec_amt;

   // S1: operand capture register
   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_rt;
   logic [SHIFT_BITS-1:0] s1_amt;
   logic                  s1_left;
   logic                  s1_arith;
   logic [REG_ADDR_W-1:0] s1_rd;
   logic                  s1_illegal;

   // S2: result register, drives the output ports directly
   logic                  s2_valid;
   logic [DATA_WIDTH-1:0] s2_result;
   logic [REG_ADDR_W-1:0] s2_rd;
   logic                  s2_illegal;

   logic                  s2_load;
   logic                  s1_free;
   logic                  accept;
   logic [DATA_WIDTH-1:0] shift_result;

   // Only the low rs bits form a variable shift amount; the rest are ignored
   logic unused_rs_bits;
   assign unused_rs_bits = ^in_rs[DATA_WIDTH-1:SHIFT_BITS];

   // Funct decode: direction, fill mode, amount source, legality
   always_comb begin
      dec_left    = 1'b0;
      dec_arith   = 1'b0;
      dec_var     = 1'b0;
      dec_illegal = 1'b0;
      case (in_funct)
         FUNCT_SLL:  dec_left = 1'b1;
         FUNCT_SRL:  ;
         FUNCT_SRA:  dec_arith = 1'b1;
         FUNCT_SLLV: begin dec_left  = 1'b1; dec_var = 1'b1; end
         FUNCT_SRLV: dec_var = 1'b1;
         FUNCT_SRAV: begin dec_arith = 1'b1; dec_var = 1'b1; end
         default:    dec_illegal = 1'b1;
      endcase
   end

   assign dec_amt = dec_var ? in_rs[SHIFT_BITS-1:0] : in_shamt;

   // S2 takes S1 whenever S2 is empty or its result is being consumed;
   // S1 is free when empty or draining into S2 this cycle.
   assign s2_load  = s1_valid & (~s2_valid | out_ready);
   assign s1_free  = ~s1_valid | s2_load;
   assign in_ready = s1_free;
   // A flush discards anything presented in the same cycle
   assign accept   = in_valid & s1_free & ~flush;

   // Shifter operating on S1 contents; illegal ops produce zero
   always_comb begin
      shift_result = '0;
      if (s1_illegal) begin
         shift_result = '0;
      end else if (s1_left) begin
         shift_result = s1_rt << s1_amt;
      end else if (s1_arith) begin
         shift_result = $signed(s1_rt) >>> s1_amt;
      end else begin
         shift_result = s1_rt >> s1_amt;
      end
   end

   // S1 register: valid tracks accept/drain, data captured only on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_rt      <= '0;
         s1_amt     <= '0;
         s1_left    <= 1'b0;
         s1_arith   <= 1'b0;
         s1_rd      <= '0;
         s1_illegal <= 1'b0;
      end else begin
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (s1_free) begin
            s1_valid <= in_valid;
         end
         if (accept) begin
            s1_rt      <= in_rt;
            s1_amt     <= dec_amt;
            s1_left    <= dec_left;
            s1_arith   <= dec_arith;
            s1_rd      <= in_rd;
            s1_illegal <= dec_illegal;
         end
      end
   end

   // S2 register: loads from S1, holds under backpressure, empties on consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         s2_result  <= '0;
         s2_rd      <= '0;
         s2_illegal <= 1'b0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s2_load) begin
         s2_valid   <= 1'b1;
         s2_result  <= shift_result;
         s2_rd      <= s1_rd;
         s2_illegal <= s1_illegal;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign out_valid   = s2_valid;
   assign out_result  = s2_result;
   assign out_rd      = s2_rd;
   assign out_illegal = s2_illegal;
   assign busy        = s1_valid | s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_exec_stage
// Function : Self-checking bench for shift_exec_stage: vector table, directed
//            backpressure/flush/reset sequences and a random stream checked
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_exec_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_funct = '0;
   logic [4:0]  in_shamt = '0;
   logic [31:0] in_rs = '0;
   logic [31:0] in_rt = '0;
   logic [4:0]  in_rd = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;
   logic        busy;

   int checks = 0;
   int errors = 0;

   shift_exec_stage #(.SHIFT_BITS(5), .DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: MIPS shift semantics in plain arithmetic
   function automatic logic [37:0] ref_op(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [4:0] rd);
      logic [31:0] ones;
      logic [31:0] res;
      int          amt;
      logic        ill;
      ones = 32'hFFFF_FFFF;
      ill  = 1'b0;
      amt  = (f[2]) ? int'(rs % 32) : int'(sh);
      case (f)
         6'd0, 6'd4: res = rt << amt;
         6'd2, 6'd6: res = rt >> amt;
         6'd3, 6'd7: res = (rt >> amt) | ((rt[31] && amt != 0) ? ~(ones >> amt) : 32'd0);
         default: begin res = 32'd0; ill = 1'b1; end
      endcase
      return {ill, rd, res};
   endfunction

   // Scoreboard driven from the negative edge, where handshakes are settled
   logic [37:0] expq[$];
   logic [31:0] seen[$];
   logic        hold_valid = 1'b0;
   logic [37:0] hold_val;

   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         hold_valid = 1'b0;
      end else begin
         if (hold_valid && out_valid)
            chk("hold_stable", {26'd0, out_illegal, out_rd} ^ {26'd0, hold_val[37:32]}
                ^ (out_result ^ hold_val[31:0]), 32'd0);
         hold_valid = out_valid && !out_ready && !flush;
         hold_val   = {out_illegal, out_rd, out_result};
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               logic [37:0] e;
               e = expq.pop_front();
               chk("sb_result", out_result, e[31:0]);
               chk("sb_rd_ill", {26'd0, out_illegal, out_rd}, {26'd0, e[37:32]});
            end
            seen.push_back(out_result);
         end
         if (flush) expq.delete();
         else if (in_valid && in_ready)
            expq.push_back(ref_op(in_funct, in_shamt, in_rs, in_rt, in_rd));
      end
   end

   // Present one op and hold it until accepted (bounded)
   task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
      logic acc;
      in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_rd = rd;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  rd;
      logic [31:0] exp_res;
      logic        exp_ill;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{6'h00, 5'd4,  32'h0,         32'h0000_00F1, 5'd9,  32'h0000_0F10, 1'b0};
      tbl[1] = '{6'h07, 5'd0,  32'hFFFF_FFE4, 32'h8000_0000, 5'd1,  32'hF800_0000, 1'b0};
      tbl[2] = '{6'h06, 5'd0,  32'hFFFF_FFE4, 32'h8000_0000, 5'd2,  32'h0800_0000, 1'b0};
      tbl[3] = '{6'h02, 5'd31, 32'h0,         32'h8000_0000, 5'd4,  32'h0000_0001, 1'b0};
      tbl[4] = '{6'h00, 5'd0,  32'h0,         32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b0};
      tbl[5] = '{6'h20, 5'd7,  32'h0,         32'h0000_1234, 5'd3,  32'h0000_0000, 1'b1};
      tbl[6] = '{6'h04, 5'd9,  32'h0000_0123, 32'h0000_0011, 5'd6,  32'h0000_0088, 1'b0};
      tbl[7] = '{6'h03, 5'd8,  32'h0,         32'h7F00_0000, 5'd7,  32'h007F_0000, 1'b0};

      // Reset state
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_flags", {26'd0, out_illegal, busy, out_rd}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Vector table: latency and value of each op
      for (int i = 0; i < 8; i++) begin
         in_funct = tbl[i].funct; in_shamt = tbl[i].shamt; in_rs = tbl[i].rs;
         in_rt = tbl[i].rt; in_rd = tbl[i].rd; in_valid = 1'b1;
         chk("tbl_in_ready", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("tbl_early_valid", {31'd0, out_valid}, 32'd0);
         @(posedge clk); #1;
         chk("tbl_valid", {31'd0, out_valid}, 32'd1);
         chk("tbl_result", out_result, tbl[i].exp_res);
         chk("tbl_rd_ill", {26'd0, out_illegal, out_rd}, {26'd0, tbl[i].exp_ill, tbl[i].rd});
         @(posedge clk); #1;
      end

      // Backpressure: A,B held, C stalls; release drains 2,4,6 in order
      seen.delete();
      out_ready = 1'b0;
      fork
         begin
            send(6'h00, 5'd1, 32'd0, 32'd1, 5'd10);
            send(6'h00, 5'd1, 32'd0, 32'd2, 5'd11);
            send(6'h00, 5'd1, 32'd0, 32'd3, 5'd12);
         end
         begin
            repeat (4) @(posedge clk);
            #3;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_result", out_result, 32'h2);
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      chk("bp_count", seen.size(), 32'd3);
      if (seen.size() == 3) begin
         chk("bp_order0", seen[0], 32'h2);
         chk("bp_order1", seen[1], 32'h4);
         chk("bp_order2", seen[2], 32'h6);
      end

      // Flush with S1, S2 full and a third op presented
      out_ready = 1'b0;
      send(6'h02, 5'd1, 32'd0, 32'h10, 5'd1);
      send(6'h02, 5'd2, 32'd0, 32'h10, 5'd2);
      in_funct = 6'h02; in_shamt = 5'd3; in_rt = 32'h10; in_rd = 5'd3; in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      // Flush while the stage would accept: the op is discarded
      out_ready = 1'b1;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("flush_discard", {30'd0, busy, out_valid}, 32'd0);
      send(6'h00, 5'd8, 32'd0, 32'h0000_00AB, 5'd20);
      @(posedge clk); #1;
      chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
      chk("post_flush_result", out_result, 32'h0000_AB00);
      @(posedge clk); #1;

      // Asynchronous reset with a result waiting
      out_ready = 1'b0;
      send(6'h00, 5'd4, 32'd0, 32'h0000_0001, 5'd8);
      @(posedge clk); #1;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_result", out_result, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;

      // Random stream against the scoreboard model
      for (int c = 0; c < 400; c++) begin
         int sel;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: in_funct = 6'h00; 1: in_funct = 6'h02; 2: in_funct = 6'h03;
            3: in_funct = 6'h04; 4: in_funct = 6'h06; 5: in_funct = 6'h07;
            default: in_funct = 6'($urandom_range(0, 63));
         endcase
         in_shamt  = 5'($urandom);
         in_rs     = $urandom;
         in_rt     = $urandom;
         in_rd     = 5'($urandom);
         in_valid  = ($urandom_range(0, 9) < 6);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 99) < 3);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && (busy || expq.size() != 0); k++) @(posedge clk);
      #1;
      chk("drain_queue", expq.size(), 32'd0);
      chk("drain_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
